port_alloc: RTL and testbench
=============================

Name: port_alloc

Overview:
- Output-port allocator for the bufferless deflection router, one stage downstream of the per-port route computation.
- Consumes the 5-bit productive vectors of the four link-input flits (N, S, E, W) together with their ages.
- Assigns every valid flit exactly one distinct output: the four links or the local eject port. A flit that cannot get a productive port is deflected.
- Result is registered: one pipeline stage feeding the crossbar/permutation stage.

Parameters:
- NUM_IN, 4, number of link-input flits allocated per cycle.
- NUM_PORT, 5, output ports; bit order [0]=W, [1]=E, [2]=S, [3]=N, [4]=local eject.
- WIDTH_AGE, 8, width of each flit age field (hop count), compared unsigned.

Ports:
- clk  input  1  clock; all state updates on its rising edge.
- reset  input  1  synchronous, active-high reset.
- stall  input  1  holds all registered state when high.
- in_valid  input  NUM_IN  per-input flit valid.
- in_prod  input  NUM_IN*NUM_PORT  productive vector of input i in bits [5i+4:5i].
- in_age  input  NUM_IN*WIDTH_AGE  age of input i in bits [WIDTH_AGE*i+WIDTH_AGE-1 : WIDTH_AGE*i].
- out_valid  output  NUM_IN  registered copy of in_valid.
- out_grant  output  NUM_IN*NUM_PORT  one-hot granted port of input i, same packing as in_prod; all zero if input i is invalid.
- out_deflect  output  NUM_IN  input i was granted a non-productive port.

Behaviour:
- Reset (synchronous, active-high), applied at a clk edge with reset=1: out_valid=0, out_grant=0, out_deflect=0, rr_ptr=0. Reset overrides stall. A reset asserted mid-stream discards the in-flight allocation; no partial grant survives.
- Latency: inputs sampled at edge t give outputs valid after edge t (1 cycle). Allocation logic is combinational between the input and the output registers.
- Priority rank: larger in_age first. Equal ages are broken by circular distance from rr_ptr (2-bit); input rr_ptr ranks highest, then rr_ptr+1, and so on, mod 4. Invalid inputs are not ranked.
- Allocation is sequential in rank order against a free-port mask that starts all free:
  - The flit takes the lowest-index free port set in its prod vector.
  - Otherwise it takes the lowest-index free link port (0..3) and its deflect bit is set.
  - The eject port (4) is never a deflection target.
- Completeness: at most 4 valid flits and 4 link ports, so every valid flit always receives a port. out_grant columns are mutually exclusive across inputs.
- A valid flit with prod=0 (illegal) is handled as a deflection; no error flag is raised.
- Two or more flits with prod[4]=1: the highest-ranked one ejects; the others are deflected onto links.
- rr_ptr advances by 1 (wrapping 3->0) at each non-stalled, non-reset edge on which any in_valid bit is 1. Otherwise it holds.
- stall=1 (and reset=0): out_valid, out_grant, out_deflect and rr_ptr all hold their values; inputs are ignored that cycle.

Optional Feature:
- Macro DEFLECT_CNT_EN.
- When defined: adds output port defl_count [15:0].
  - On every non-stalled edge it adds the popcount of the next out_deflect value.
  - It saturates at 16'hFFFF and does not wrap.
  - Reset sets it to 0; stall holds it.
- When undefined: the port and counter do not exist; all other behaviour is identical.

Test Plan:
- Age priority: after reset, in_valid=4'b0011, prod0=prod1=5'b00001, age0=3, age1=7 -> next cycle grant1=5'b00001, grant0=5'b00010, out_deflect=4'b0001.
- Round-robin tie: after reset, inputs 0 and 1 valid, both prod=5'b00100, age 5, for 2 cycles:
  - Cycle 1 (rr_ptr=0): grant0=5'b00100, grant1=5'b00001.
  - Cycle 2 (rr_ptr=1): grant1=5'b00100, grant0=5'b00001.
- Eject contention: inputs 2,3 valid, prod=5'b10000, age2=1, age3=2 -> grant3=5'b10000, grant2=5'b00001, out_deflect=4'b0100.
- Full load: all 4 valid, all prod=5'b01000, ages 4,3,2,1 -> grant0=5'b01000, grant1=5'b00001, grant2=5'b00010, grant3=5'b00100, out_deflect=4'b1110.
- Stall/reset: assert stall for 3 cycles while the inputs change -> outputs and rr_ptr unchanged. Then assert reset with stall=1 -> all outputs 0 and rr_ptr=0 after the edge.
- DEFLECT_CNT_EN: repeat the full-load vector 3 cycles -> defl_count=9. Preload near saturation via a long run -> the count holds at 16'hFFFF.

Source files
------------

// File: rtl/port_alloc_if.sv
// Allocator-side bundle: per-input flit descriptors in, registered grants out.
// Direction is named from the driving stage (master) and the allocator (slave).
interface port_alloc_if #(
  parameter int NUM_IN    = 4,
  parameter int NUM_PORT  = 5,
  parameter int WIDTH_AGE = 8
);
  logic                          stall;
  logic [NUM_IN-1:0]             in_valid;
  logic [NUM_IN*NUM_PORT-1:0]    in_prod;
  logic [NUM_IN*WIDTH_AGE-1:0]   in_age;
  logic [NUM_IN-1:0]             out_valid;
  logic [NUM_IN*NUM_PORT-1:0]    out_grant;
  logic [NUM_IN-1:0]             out_deflect;

  modport master (
    output stall, in_valid, in_prod, in_age,
    input  out_valid, out_grant, out_deflect
  );

  modport slave (
    input  stall, in_valid, in_prod, in_age,
    output out_valid, out_grant, out_deflect
  );
endinterface

// File: rtl/port_alloc.sv
// Output-port allocator for a bufferless deflection router: oldest flit first, ties by round-robin.
// Defining DEFLECT_CNT_EN adds a 16-bit saturating deflection counter output (defl_count).
module port_alloc #(
  parameter int NUM_IN    = 4,
  parameter int NUM_PORT  = 5,
  parameter int WIDTH_AGE = 8
) (
  input  logic        clk,
  input  logic        reset,
  port_alloc_if.slave bus
`ifdef DEFLECT_CNT_EN
  ,
  output logic [15:0] defl_count
`endif
);
  localparam int PTR_W = $clog2(NUM_IN);
  localparam int CNT_W = $clog2(NUM_IN + 1);
  localparam logic [NUM_PORT-1:0] LINK_MASK = {1'b0, {(NUM_PORT-1){1'b1}}};

  logic [PTR_W-1:0]           rr_ptr_r;
  logic [PTR_W-1:0]           rank_s [NUM_IN];
  logic [NUM_PORT-1:0]        free_s;
  logic [NUM_PORT-1:0]        pick_s;
  logic [NUM_IN*NUM_PORT-1:0] grant_s;
  logic [NUM_IN-1:0]          defl_s;
  logic [NUM_IN-1:0]          out_valid_r;
  logic [NUM_IN*NUM_PORT-1:0] out_grant_r;
  logic [NUM_IN-1:0]          out_defl_r;

  function automatic logic [NUM_PORT-1:0] lowest_one(input logic [NUM_PORT-1:0] v);
    return v & (~v + NUM_PORT'(1));
  endfunction

  function automatic logic outranks(input logic [WIDTH_AGE-1:0] age_a,
                                    input logic [WIDTH_AGE-1:0] age_b,
                                    input logic [PTR_W-1:0]     dist_a,
                                    input logic [PTR_W-1:0]     dist_b);
    return (age_a > age_b) || ((age_a == age_b) && (dist_a < dist_b));
  endfunction

  // Rank of each input = number of valid inputs that beat it (an input never beats itself).
  always_comb begin
    for (int i = 0; i < NUM_IN; i++) begin
      rank_s[i] = '0;
      for (int j = 0; j < NUM_IN; j++) begin
        rank_s[i] = rank_s[i] + PTR_W'(bus.in_valid[j] &&
                    outranks(bus.in_age[j*WIDTH_AGE +: WIDTH_AGE],
                             bus.in_age[i*WIDTH_AGE +: WIDTH_AGE],
                             PTR_W'(j) - rr_ptr_r,
                             PTR_W'(i) - rr_ptr_r));
      end
    end
  end

  // Serve flits in rank order against a shrinking free-port mask; links always suffice for deflection.
  always_comb begin
    free_s  = '1;
    pick_s  = '0;
    grant_s = '0;
    defl_s  = '0;
    for (int r = 0; r < NUM_IN; r++) begin
      for (int i = 0; i < NUM_IN; i++) begin
        if (bus.in_valid[i] && (rank_s[i] == PTR_W'(r))) begin
          pick_s = lowest_one(bus.in_prod[i*NUM_PORT +: NUM_PORT] & free_s);
          if (pick_s == '0) begin
            pick_s    = lowest_one(free_s & LINK_MASK);
            defl_s[i] = 1'b1;
          end else begin
            defl_s[i] = 1'b0;
          end
          grant_s[i*NUM_PORT +: NUM_PORT] = pick_s;
          free_s = free_s & ~pick_s;
        end else begin
          free_s = free_s;
        end
      end
    end
  end

  // Output pipeline register and round-robin pointer; stall freezes everything, reset wins.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid_r <= '0;
      out_grant_r <= '0;
      out_defl_r  <= '0;
      rr_ptr_r    <= '0;
    end else if (!bus.stall) begin
      out_valid_r <= bus.in_valid;
      out_grant_r <= grant_s;
      out_defl_r  <= defl_s;
      rr_ptr_r    <= (|bus.in_valid) ? rr_ptr_r + PTR_W'(1) : rr_ptr_r;
    end else begin
      out_valid_r <= out_valid_r;
      out_grant_r <= out_grant_r;
      out_defl_r  <= out_defl_r;
      rr_ptr_r    <= rr_ptr_r;
    end
  end

  assign bus.out_valid   = out_valid_r;
  assign bus.out_grant   = out_grant_r;
  assign bus.out_deflect = out_defl_r;

`ifdef DEFLECT_CNT_EN
  logic [15:0] defl_count_r;
  logic [16:0] defl_sum_s;

  function automatic logic [CNT_W-1:0] popcount(input logic [NUM_IN-1:0] v);
    logic [CNT_W-1:0] n;
    n = '0;
    for (int k = 0; k < NUM_IN; k++) begin
      n = n + CNT_W'(v[k]);
    end
    return n;
  endfunction

  // One spare bit catches the carry so the count can clamp instead of wrapping.
  always_comb begin
    defl_sum_s = {1'b0, defl_count_r} + 17'(popcount(defl_s));
  end

  // Saturating deflection counter, held by stall.
  always_ff @(posedge clk) begin
    if (reset) begin
      defl_count_r <= 16'h0000;
    end else if (!bus.stall) begin
      defl_count_r <= defl_sum_s[16] ? 16'hFFFF : defl_sum_s[15:0];
    end else begin
      defl_count_r <= defl_count_r;
    end
  end

  assign defl_count = defl_count_r;
`endif
endmodule

// File: tb/tb_port_alloc.sv
// Directed bench for port_alloc: table of single-cycle vectors plus round-robin, stall/reset and counter sequences.
module tb_port_alloc;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  port_alloc_if #(.NUM_IN(4), .NUM_PORT(5), .WIDTH_AGE(8)) bus ();
`ifdef DEFLECT_CNT_EN
  logic [15:0] defl_count;
`endif

  port_alloc dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
`ifdef DEFLECT_CNT_EN
    ,
    .defl_count (defl_count)
`endif
  );

  typedef struct {
    string       name;
    logic [3:0]  valid;
    logic [19:0] prod;
    logic [31:0] age;
    logic [19:0] grant;
    logic [3:0]  defl;
  } vec_t;

  vec_t vecs [9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [3:0] v, input logic [19:0] p, input logic [31:0] a);
    bus.in_valid = v;
    bus.in_prod  = p;
    bus.in_age   = a;
  endtask

  task automatic do_reset();
    reset     = 1'b1;
    bus.stall = 1'b0;
    tick();
    reset = 1'b0;
  endtask

  initial begin
    vecs[0] = '{"age_prio",  4'b0011, {10'b0, 5'b00001, 5'b00001}, {16'd0, 8'd7, 8'd3},
                {10'b0, 5'b00001, 5'b00010}, 4'b0001};
    vecs[1] = '{"eject",     4'b1100, {5'b10000, 5'b10000, 10'b0}, {8'd2, 8'd1, 16'd0},
                {5'b10000, 5'b00001, 10'b0}, 4'b0100};
    vecs[2] = '{"full_load", 4'b1111, {4{5'b01000}}, {8'd1, 8'd2, 8'd3, 8'd4},
                {5'b00100, 5'b00010, 5'b00001, 5'b01000}, 4'b1110};
    vecs[3] = '{"none_valid", 4'b0000, {4{5'b11111}}, 32'h12345678, 20'b0, 4'b0000};
    vecs[4] = '{"all_prod",  4'b1111, {5'b01000, 5'b00100, 5'b00010, 5'b00001}, 32'd0,
                {5'b01000, 5'b00100, 5'b00010, 5'b00001}, 4'b0000};
    vecs[5] = '{"prod_zero", 4'b0001, 20'b0, {24'd0, 8'd9}, {15'b0, 5'b00001}, 4'b0001};
    vecs[6] = '{"tie_multi", 4'b1111, {4{5'b00011}}, {4{8'd5}},
                {5'b01000, 5'b00100, 5'b00010, 5'b00001}, 4'b1100};
    vecs[7] = '{"mixed_ej",  4'b0110, {5'b0, 5'b10000, 5'b10001, 5'b0}, {8'd0, 8'd2, 8'd2, 8'd0},
                {5'b0, 5'b10000, 5'b00001, 5'b0}, 4'b0000};
    vecs[8] = '{"age_unsig", 4'b0011, {10'b0, 5'b00100, 5'b00100}, {16'd0, 8'd1, 8'hFF},
                {10'b0, 5'b00001, 5'b00100}, 4'b0010};

    bus.stall = 1'b0;
    drive(4'b0, 20'b0, 32'b0);
    do_reset();
    check("reset valid", 32'(bus.out_valid), 32'h0);
    check("reset grant", 32'(bus.out_grant), 32'h0);
    check("reset defl", 32'(bus.out_deflect), 32'h0);
    check("reset rr", 32'(dut.rr_ptr_r), 32'h0);

    for (int k = 0; k < 9; k++) begin
      do_reset();
      drive(vecs[k].valid, vecs[k].prod, vecs[k].age);
      tick();
      check($sformatf("%s valid", vecs[k].name), 32'(bus.out_valid), 32'(vecs[k].valid));
      check($sformatf("%s grant", vecs[k].name), 32'(bus.out_grant), 32'(vecs[k].grant));
      check($sformatf("%s defl", vecs[k].name), 32'(bus.out_deflect), 32'(vecs[k].defl));
    end

    // Round-robin tie over two cycles
    do_reset();
    drive(4'b0011, {10'b0, 5'b00100, 5'b00100}, {16'd0, 8'd5, 8'd5});
    tick();
    check("rr c1 grant", 32'(bus.out_grant), 32'({10'b0, 5'b00001, 5'b00100}));
    check("rr c1 defl", 32'(bus.out_deflect), 32'h2);
    tick();
    check("rr c2 grant", 32'(bus.out_grant), 32'({10'b0, 5'b00100, 5'b00001}));
    check("rr c2 defl", 32'(bus.out_deflect), 32'h1);
    check("rr c2 ptr", 32'(dut.rr_ptr_r), 32'h2);

    // Stall holds outputs and pointer while inputs change
    bus.stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      drive(4'b1111, {4{5'b01000}}, {8'd1, 8'd2, 8'd3, 8'd4 + 8'(k)});
      tick();
      check("stall valid", 32'(bus.out_valid), 32'h3);
      check("stall grant", 32'(bus.out_grant), 32'({10'b0, 5'b00100, 5'b00001}));
      check("stall defl", 32'(bus.out_deflect), 32'h1);
      check("stall rr", 32'(dut.rr_ptr_r), 32'h2);
    end
    reset = 1'b1;
    tick();
    check("rst+stall valid", 32'(bus.out_valid), 32'h0);
    check("rst+stall grant", 32'(bus.out_grant), 32'h0);
    check("rst+stall defl", 32'(bus.out_deflect), 32'h0);
    check("rst+stall rr", 32'(dut.rr_ptr_r), 32'h0);
    reset     = 1'b0;
    bus.stall = 1'b0;

    // Pointer holds on idle cycles and wraps 3 -> 0
    drive(4'b0000, 20'b0, 32'b0);
    tick();
    check("idle rr", 32'(dut.rr_ptr_r), 32'h0);
    drive(4'b1000, {5'b01000, 15'b0}, 32'd0);
    tick();
    check("single grant", 32'(bus.out_grant), 32'({5'b01000, 15'b0}));
    check("rr step", 32'(dut.rr_ptr_r), 32'h1);
    for (int k = 0; k < 3; k++) tick();
    check("rr wrap", 32'(dut.rr_ptr_r), 32'h0);

`ifdef DEFLECT_CNT_EN
    do_reset();
    check("cnt reset", 32'(defl_count), 32'h0);
    drive(4'b1111, {4{5'b01000}}, {8'd1, 8'd2, 8'd3, 8'd4});
    for (int k = 0; k < 3; k++) tick();
    check("cnt 3 cycles", 32'(defl_count), 32'd9);
    bus.stall = 1'b1;
    tick();
    check("cnt stall", 32'(defl_count), 32'd9);
    bus.stall = 1'b0;
    for (int k = 0; k < 21850; k++) tick();
    check("cnt sat", 32'(defl_count), 32'hFFFF);
    tick();
    check("cnt sat hold", 32'(defl_count), 32'hFFFF);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
